// File: rtl/lc3_control_fsm.sv
// Second-generation LC-3 control FSM: drives the datapath tri-state enables, load strobes and mux selects.
// Optional macro LC3_ILLEGAL_TRAP_EN: unsupported opcodes trap in ILL and an illegal_op output is added.
module lc3_control_fsm #(
   parameter int WORD_W      = 16,
   parameter int MEM_TIMEOUT = 15,
   parameter int STATE_W     = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   input  logic [WORD_W-1:0]  IR,
   input  logic               N,
   input  logic               Z,
   input  logic               P,
   input  logic               mem_ready,
   output logic [1:0]         aluControl,
   output logic               enaALU,
   output logic               enaMARM,
   output logic               enaMDR,
   output logic               enaPC,
   output logic               selMAR,
   output logic               selEAB1,
   output logic [1:0]         selEAB2,
   output logic [1:0]         selPC,
   output logic [1:0]         selMDR,
   output logic               ldPC,
   output logic               ldIR,
   output logic               ldMAR,
   output logic               ldMDR,
   output logic               ldCC,
   output logic [2:0]         SR1,
   output logic [2:0]         SR2,
   output logic [2:0]         DR,
   output logic               regWE,
   output logic               memWE,
   output logic               memEN,
   output logic               mem_err,
`ifdef LC3_ILLEGAL_TRAP_EN
   output logic               illegal_op,
`endif
   output logic [STATE_W-1:0] current_state
);

   typedef enum logic [5:0] {
      S_BR     = 6'd0,
      S_ADD    = 6'd1,
      S_LD     = 6'd2,
      S_ST     = 6'd3,
      S_AND    = 6'd5,
      S_NOT    = 6'd9,
      S_JMP    = 6'd12,
      S_LEA    = 6'd14,
      S_STMEM  = 6'd16,
      S_FETCH0 = 6'd18,
      S_BRT    = 6'd22,
      S_STMDR  = 6'd23,
      S_LDMEM  = 6'd25,
      S_LDWB   = 6'd27,
      S_DECODE = 6'd32,
      S_FETCH1 = 6'd33,
      S_FETCH2 = 6'd35,
      S_ILL    = 6'd62,
      S_IDLE   = 6'd63
   } state_t;

   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

`ifdef LC3_ILLEGAL_TRAP_EN
   localparam state_t UNSUPPORTED_NEXT = S_ILL;
`else
   localparam state_t UNSUPPORTED_NEXT = S_FETCH0;
`endif

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] wait_cnt;
   logic [3:0]       opcode;
   logic             in_mem;
   logic             timeout;
   logic             br_taken;
   logic             unused_ir_bits;

   assign opcode         = IR[WORD_W-1 -: 4];
   assign br_taken       = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
   assign unused_ir_bits = ^IR[5:3];
   assign current_state  = STATE_W'(state);

   // Memory handshake: memEN is held for the whole memory state; the access completes on the
   // first posedge that samples mem_ready=1. Each mem_ready=0 cycle is counted, and after
   // MEM_TIMEOUT such cycles the access is abandoned (mem_err set, back to IDLE).
   assign in_mem  = (state == S_FETCH1) || (state == S_LDMEM) || (state == S_STMEM);
   assign timeout = in_mem && !mem_ready && (wait_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         state <= next_state;
         // Leaving any memory state clears the count, so each access starts from zero.
         if (in_mem && !mem_ready && !timeout) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end else begin
            wait_cnt <= '0;
         end
         if (timeout) begin
            mem_err <= 1'b1;
         end
      end
   end

   always_comb begin
      next_state = state;
      aluControl = 2'b00;
      enaALU     = 1'b0;
      enaMARM    = 1'b0;
      enaMDR     = 1'b0;
      enaPC      = 1'b0;
      selMAR     = 1'b0;
      selEAB1    = 1'b0;
      selEAB2    = 2'b00;
      selPC      = 2'b00;
      selMDR     = 2'b00;
      ldPC       = 1'b0;
      ldIR       = 1'b0;
      ldMAR      = 1'b0;
      ldMDR      = 1'b0;
      ldCC       = 1'b0;
      SR1        = 3'd0;
      SR2        = 3'd0;
      DR         = 3'd0;
      regWE      = 1'b0;
      memWE      = 1'b0;
      memEN      = 1'b0;
`ifdef LC3_ILLEGAL_TRAP_EN
      illegal_op = 1'b0;
`endif

      case (state)
         S_IDLE: begin
            if (run) next_state = S_FETCH0;
         end

         // run is sampled here only; a stop request suppresses the fetch entirely.
         S_FETCH0: begin
            if (!run) begin
               next_state = S_IDLE;
            end else begin
               enaPC      = 1'b1;
               ldMAR      = 1'b1;
               ldPC       = 1'b1;
               selPC      = 2'b00;
               next_state = S_FETCH1;
            end
         end

         S_FETCH1: begin
            memEN  = 1'b1;
            selMDR = 2'b01;
            if (mem_ready) begin
               ldMDR      = 1'b1;
               next_state = S_FETCH2;
            end else if (timeout) begin
               next_state = S_IDLE;
            end
         end

         S_FETCH2: begin
            enaMDR     = 1'b1;
            ldIR       = 1'b1;
            next_state = S_DECODE;
         end

         S_DECODE: begin
            case (opcode)
               4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd9, 4'd12, 4'd14:
                  next_state = state_t'({2'b00, opcode});
               default:
                  next_state = UNSUPPORTED_NEXT;
            endcase
         end

         S_ADD, S_AND, S_NOT: begin
            enaALU     = 1'b1;
            regWE      = 1'b1;
            ldCC       = 1'b1;
            SR1        = IR[8:6];
            SR2        = IR[2:0];
            DR         = IR[11:9];
            aluControl = (state == S_ADD) ? 2'b01 : (state == S_AND) ? 2'b10 : 2'b11;
            next_state = S_FETCH0;
         end

         S_LEA: begin
            selEAB1    = 1'b0;
            selEAB2    = 2'b10;
            selMAR     = 1'b0;
            enaMARM    = 1'b1;
            regWE      = 1'b1;
            DR         = IR[11:9];
            next_state = S_FETCH0;
         end

         S_LD, S_ST: begin
            selEAB2    = 2'b10;
            enaMARM    = 1'b1;
            ldMAR      = 1'b1;
            next_state = (state == S_LD) ? S_LDMEM : S_STMDR;
         end

         S_LDMEM: begin
            memEN  = 1'b1;
            selMDR = 2'b01;
            if (mem_ready) begin
               ldMDR      = 1'b1;
               next_state = S_LDWB;
            end else if (timeout) begin
               next_state = S_IDLE;
            end
         end

         S_LDWB: begin
            enaMDR     = 1'b1;
            regWE      = 1'b1;
            ldCC       = 1'b1;
            DR         = IR[11:9];
            next_state = S_FETCH0;
         end

         // Store data is routed through the ALU in pass mode onto the bus and into MDR.
         S_STMDR: begin
            SR1        = IR[11:9];
            aluControl = 2'b00;
            enaALU     = 1'b1;
            selMDR     = 2'b00;
            ldMDR      = 1'b1;
            next_state = S_STMEM;
         end

         S_STMEM: begin
            memEN = 1'b1;
            memWE = 1'b1;
            if (mem_ready) begin
               next_state = S_FETCH0;
            end else if (timeout) begin
               next_state = S_IDLE;
            end
         end

         S_BR: begin
            next_state = br_taken ? S_BRT : S_FETCH0;
         end

         S_BRT: begin
            selEAB2    = 2'b10;
            selPC      = 2'b10;
            ldPC       = 1'b1;
            next_state = S_FETCH0;
         end

         S_JMP: begin
            SR1        = IR[8:6];
            selEAB1    = 1'b1;
            selEAB2    = 2'b00;
            selPC      = 2'b10;
            ldPC       = 1'b1;
            next_state = S_FETCH0;
         end

         S_ILL: begin
`ifdef LC3_ILLEGAL_TRAP_EN
            illegal_op = 1'b1;
`endif
            next_state = S_ILL;
         end

         default: next_state = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Bench for lc3_control_fsm: a per-cycle expected trace is built from instruction-level rules and
// compared against the DUT; table vectors, random instructions and hand-written corner sequences.
module tb_lc3_control_fsm;
   localparam int WORD_W  = 16;
   localparam int MT      = 15;
   localparam int STATE_W = 6;

   typedef struct packed {
      logic [1:0] alu;
      logic       ena_alu, ena_marm, ena_mdr, ena_pc;
      logic       sel_mar, sel_eab1;
      logic [1:0] sel_eab2, sel_pc, sel_mdr;
      logic       ld_pc, ld_ir, ld_mar, ld_mdr, ld_cc;
      logic [2:0] sr1, sr2, dr;
      logic       reg_we, mem_we, mem_en;
   } ctl_t;

   typedef struct packed {
      logic [15:0] ir;
      logic        n, z, p, run, mem_ready;
      logic [5:0]  st;
      ctl_t        ctl;
      logic        err, ill;
   } cyc_t;

   localparam int CYC_W = $bits(cyc_t);

   typedef struct {
      logic [15:0] ir;
      logic [2:0]  nzp;
      int          fw;
      int          mw;
      bit          stall;
   } vec_t;

   logic clk, reset, run, N, Z, P, mem_ready;
   logic [WORD_W-1:0]  IR;
   logic [1:0]  aluControl, selEAB2, selPC, selMDR;
   logic        enaALU, enaMARM, enaMDR, enaPC, selMAR, selEAB1;
   logic        ldPC, ldIR, ldMAR, ldMDR, ldCC, regWE, memWE, memEN, mem_err;
   logic [2:0]  SR1, SR2, DR;
   logic [STATE_W-1:0] current_state;
   logic        ill_act;
   ctl_t        act_ctl;

   logic [CYC_W-1:0] exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;
   logic [15:0] g_ir;
   logic g_n, g_z, g_p, g_err, g_ill;

   lc3_control_fsm #(.WORD_W(WORD_W), .MEM_TIMEOUT(MT), .STATE_W(STATE_W)) dut (
      .clk(clk), .reset(reset), .run(run), .IR(IR), .N(N), .Z(Z), .P(P), .mem_ready(mem_ready),
      .aluControl(aluControl), .enaALU(enaALU), .enaMARM(enaMARM), .enaMDR(enaMDR), .enaPC(enaPC),
      .selMAR(selMAR), .selEAB1(selEAB1), .selEAB2(selEAB2), .selPC(selPC), .selMDR(selMDR),
      .ldPC(ldPC), .ldIR(ldIR), .ldMAR(ldMAR), .ldMDR(ldMDR), .ldCC(ldCC),
      .SR1(SR1), .SR2(SR2), .DR(DR), .regWE(regWE), .memWE(memWE), .memEN(memEN),
      .mem_err(mem_err),
`ifdef LC3_ILLEGAL_TRAP_EN
      .illegal_op(ill_act),
`endif
      .current_state(current_state)
   );

`ifndef LC3_ILLEGAL_TRAP_EN
   assign ill_act = 1'b0;
`endif

   assign act_ctl = {aluControl, enaALU, enaMARM, enaMDR, enaPC, selMAR, selEAB1, selEAB2, selPC,
                     selMDR, ldPC, ldIR, ldMAR, ldMDR, ldCC, SR1, SR2, DR, regWE, memWE, memEN};

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // scoreboard
   task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_cycle(input cyc_t e);
      n_cmp++;
      if (current_state !== e.st || act_ctl !== e.ctl || mem_err !== e.err || ill_act !== e.ill) begin
         n_bad++;
         $display("FAIL cycle ir=%h: got st=%0d ctl=%h err=%b ill=%b expected st=%0d ctl=%h err=%b ill=%b",
                  e.ir, current_state, act_ctl, mem_err, ill_act, e.st, e.ctl, e.err, e.ill);
      end
   endtask

   // driver
   task automatic push(input logic [5:0] st, input ctl_t c, input logic run_v, input logic mr);
      cyc_t e;
      e.ir = g_ir; e.n = g_n; e.z = g_z; e.p = g_p;
      e.run = run_v; e.mem_ready = mr;
      e.st = st; e.ctl = c; e.err = g_err; e.ill = g_ill;
      exp_q.push_back(e);
   endtask

   task automatic run_trace();
      cyc_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         @(posedge clk); #1;
         IR = e.ir; N = e.n; Z = e.z; P = e.p; run = e.run; mem_ready = e.mem_ready;
         @(negedge clk);
         check_cycle(e);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0; run = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("reset_state", 64'(current_state), 64'd63);
      check_eq("reset_ctl", 64'(act_ctl), 64'd0);
      check_eq("reset_err", 64'({mem_err, ill_act}), 64'd0);
      reset = 1'b1;
      g_err = 1'b0; g_ill = 1'b0;
   endtask

   // Memory access: `waits` not-ready cycles then one ready cycle; MT or more waits is a timeout.
   task automatic push_mem(input logic [5:0] st, input ctl_t base, input ctl_t on_ready,
                           input int waits, output bit ok);
      ok = 1'b1;
      for (int i = 0; i < waits && i < MT; i++) push(st, base, rb(), 1'b0);
      if (waits >= MT) begin
         g_err = 1'b1;
         push(6'd63, '0, 1'b1, rb());
         ok = 1'b0;
      end else begin
         push(st, ctl_t'(base | on_ready), rb(), 1'b1);
      end
   endtask

   task automatic gen_instr(input logic [15:0] ir, input logic [2:0] nzp, input int fw, input int mw,
                            input bit stall);
      ctl_t c, x;
      bit ok;
      logic [3:0] op;
      g_ir = ir; {g_n, g_z, g_p} = nzp; op = ir[15:12];
      if (stall) begin
         push(6'd18, '0, 1'b0, rb());
         push(6'd63, '0, 1'b1, rb());
      end
      c = '0; c.ena_pc = 1; c.ld_mar = 1; c.ld_pc = 1;
      push(6'd18, c, 1'b1, rb());
      c = '0; c.mem_en = 1; c.sel_mdr = 2'b01;
      x = '0; x.ld_mdr = 1;
      push_mem(6'd33, c, x, fw, ok);
      if (!ok) return;
      c = '0; c.ena_mdr = 1; c.ld_ir = 1;
      push(6'd35, c, rb(), rb());
      push(6'd32, '0, rb(), rb());
      c = '0;
      case (op)
         4'd1, 4'd5, 4'd9: begin
            c.alu = (op == 4'd1) ? 2'b01 : (op == 4'd5) ? 2'b10 : 2'b11;
            c.ena_alu = 1; c.reg_we = 1; c.ld_cc = 1;
            c.sr1 = ir[8:6]; c.sr2 = ir[2:0]; c.dr = ir[11:9];
            push({2'b00, op}, c, rb(), rb());
         end
         4'd14: begin
            c.sel_eab2 = 2'b10; c.ena_marm = 1; c.reg_we = 1; c.dr = ir[11:9];
            push(6'd14, c, rb(), rb());
         end
         4'd2, 4'd3: begin
            c.sel_eab2 = 2'b10; c.ena_marm = 1; c.ld_mar = 1;
            push({2'b00, op}, c, rb(), rb());
            if (op == 4'd2) begin
               c = '0; c.mem_en = 1; c.sel_mdr = 2'b01;
               x = '0; x.ld_mdr = 1;
               push_mem(6'd25, c, x, mw, ok);
               if (!ok) return;
               c = '0; c.ena_mdr = 1; c.reg_we = 1; c.ld_cc = 1; c.dr = ir[11:9];
               push(6'd27, c, rb(), rb());
            end else begin
               c = '0; c.sr1 = ir[11:9]; c.ena_alu = 1; c.ld_mdr = 1;
               push(6'd23, c, rb(), rb());
               c = '0; c.mem_en = 1; c.mem_we = 1;
               push_mem(6'd16, c, '0, mw, ok);
            end
         end
         4'd0: begin
            push(6'd0, '0, rb(), rb());
            if ((ir[11] & g_n) | (ir[10] & g_z) | (ir[9] & g_p)) begin
               c.sel_eab2 = 2'b10; c.sel_pc = 2'b10; c.ld_pc = 1;
               push(6'd22, c, rb(), rb());
            end
         end
         4'd12: begin
            c.sr1 = ir[8:6]; c.sel_eab1 = 1; c.sel_pc = 2'b10; c.ld_pc = 1;
            push(6'd12, c, rb(), rb());
         end
         default: begin
`ifdef LC3_ILLEGAL_TRAP_EN
            g_ill = 1'b1;
            for (int i = 0; i < 4; i++) push(6'd62, '0, rb(), rb());
`endif
         end
      endcase
   endtask

   vec_t tbl[15];
   logic [3:0] ops[8];

   initial begin
      bit found;
      logic [3:0] op;
      reset = 1'b0; run = 1'b0; IR = '0; N = 0; Z = 0; P = 0; mem_ready = 1'b0;
      g_ir = '0; g_n = 0; g_z = 0; g_p = 0; g_err = 0; g_ill = 0;

      tbl[0]  = '{16'h1843, 3'b000, 0, 0, 1'b0};     // ADD R4,R1,R3
      tbl[1]  = '{16'h5A7F, 3'b001, 2, 0, 1'b0};     // AND immediate
      tbl[2]  = '{16'h967F, 3'b000, 1, 0, 1'b0};     // NOT R3,R1
      tbl[3]  = '{16'hE5FF, 3'b100, 0, 0, 1'b0};     // LEA R2
      tbl[4]  = '{16'h2405, 3'b000, 0, 3, 1'b0};     // LD R2, ready late
      tbl[5]  = '{16'h3A05, 3'b000, 1, 2, 1'b0};     // ST R5
      tbl[6]  = '{16'h0A03, 3'b010, 0, 0, 1'b0};     // BRnp, Z -> not taken
      tbl[7]  = '{16'h0A03, 3'b100, 0, 0, 1'b0};     // BRnp, N -> taken
      tbl[8]  = '{16'hC1C0, 3'b000, 0, 0, 1'b1};     // JMP R7 after run=0 stop
      tbl[9]  = '{16'h1843, 3'b000, MT - 1, 0, 1'b0}; // fetch ready on last allowed cycle
      tbl[10] = '{16'h2405, 3'b000, 0, MT - 1, 1'b0}; // load ready on last allowed cycle
      tbl[11] = '{16'h1843, 3'b000, MT, 0, 1'b0};    // fetch timeout
      tbl[12] = '{16'h2405, 3'b000, 0, MT, 1'b0};    // load timeout
      tbl[13] = '{16'h3A05, 3'b000, 0, MT, 1'b0};    // store timeout
      tbl[14] = '{16'h5042, 3'b000, 0, 0, 1'b0};     // AND after errors: mem_err stays set

      // table-driven vectors
      do_reset();
      push(6'd63, '0, 1'b1, rb());
      foreach (tbl[i]) gen_instr(tbl[i].ir, tbl[i].nzp, tbl[i].fw, tbl[i].mw, tbl[i].stall);
      run_trace();

      // randomized instructions
      do_reset();
      push(6'd63, '0, 1'b1, rb());
      ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd9, 4'd12, 4'd14};
      for (int k = 0; k < 80; k++) begin
         op = ops[$urandom_range(0, 7)];
`ifndef LC3_ILLEGAL_TRAP_EN
         if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(0, 15));
`endif
         gen_instr({op, 12'($urandom)}, 3'($urandom_range(0, 7)),
                   ($urandom_range(0, 7) == 0) ? MT - 1 : $urandom_range(0, 4),
                   ($urandom_range(0, 7) == 0) ? MT - 1 : $urandom_range(0, 4),
                   $urandom_range(0, 9) == 0);
         run_trace();
      end

      // unsupported opcode
      do_reset();
      push(6'd63, '0, 1'b1, rb());
      gen_instr(16'hD000, 3'b000, 0, 0, 1'b0);
`ifndef LC3_ILLEGAL_TRAP_EN
      gen_instr(16'h1843, 3'b000, 0, 0, 1'b0);
`endif
      run_trace();

      // reset asserted while a store is waiting on memory
      do_reset();
      IR = 16'h3A05; run = 1'b1; mem_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(posedge clk); #1;
         if (current_state == 6'd23) mem_ready = 1'b0;
         if (current_state == 6'd16) found = 1'b1;
      end
      check_eq("reach_stmem", 64'(found), 64'd1);
      @(negedge clk);
      check_eq("stmem_we", 64'({memWE, memEN}), 64'd3);
      #2 reset = 1'b0;
      #1;
      check_eq("async_we", 64'({memWE, memEN}), 64'd0);
      check_eq("async_state", 64'(current_state), 64'd63);
      check_eq("async_ctl", 64'(act_ctl), 64'd0);
      @(posedge clk); #1;
      check_eq("held_state", 64'(current_state), 64'd63);
      check_eq("held_err", 64'(mem_err), 64'd0);
      reset = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lc3_control_fsm.md
Name: lc3_control_fsm

Overview:
- Parametrised second-generation LC-3 control state machine.
- Drives the same datapath control bus as the first-generation controller: tri-state enables, register/memory load strobes and mux selects.
- New over the first generation: single-edge operation, a run/idle gate, a memory ready handshake with timeout, condition-code load, and execution of LD, ST, BR and JMP in addition to ADD, AND, NOT and LEA.

Parameters:
- WORD_W, 16, IR/instruction word width; opcode is IR[WORD_W-1:WORD_W-4].
- MEM_TIMEOUT, 15, maximum cycles spent waiting for mem_ready in any memory state; range 1..255.
- STATE_W, 6, width of current_state; must be at least 6.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  level; leaves IDLE when 1.
- IR  in  WORD_W  current instruction register.
- N,Z,P  in  1 each  condition codes from datapath.
- mem_ready  in  1  memory access complete, sampled on posedge.
- aluControl  out  2  01 ADD, 10 AND, 11 NOT, 00 pass.
- enaALU, enaMARM, enaMDR, enaPC  out  1 each  bus tri-state enables; at most one high.
- selMAR, selEAB1  out  1 each  address mux selects.
- selEAB2, selPC, selMDR  out  2 each  mux selects.
- ldPC, ldIR, ldMAR, ldMDR, ldCC  out  1 each  load strobes.
- SR1, SR2, DR  out  3 each  register file addresses.
- regWE, memWE, memEN  out  1 each  write enables / memory request.
- mem_err  out  1  sticky; memory timeout occurred.
- current_state  out  STATE_W  state code, for debug.

Behaviour:
- Reset (async, reset=0): current_state=IDLE (63), wait counter=0, mem_err=0. Every control output is 0 while in reset and in IDLE.
- Moore outputs: decoded combinationally from current_state and IR. Any output not listed for a state is 0.
- SR1/SR2/DR: taken from IR[8:6]/IR[2:0]/IR[11:9] in execute states. DR is IR[11:9] for ADD, AND, NOT, LEA and LD.
- IDLE(63): run=1 -> FETCH0; otherwise stay.
- FETCH0(18): enaPC, ldMAR, ldPC, selPC=00 -> FETCH1.
- FETCH1(33): memEN, selMDR=01. On mem_ready, ldMDR=1 and go to FETCH2; else stay.
- FETCH2(35): enaMDR, ldIR -> DECODE(32).
- DECODE(32): next state = {00, opcode}.
- ADD(1), AND(5), NOT(9): enaALU, regWE, ldCC, matching aluControl -> FETCH0.
  - IR[5]=1 selects the immediate; SR2 is still driven.
- LEA(14): selEAB1=0, selEAB2=10, selMAR=0, enaMARM, regWE -> FETCH0. No ldCC.
- LD(2): selEAB2=10, enaMARM, ldMAR -> LDMEM(25).
- LDMEM(25): memEN, selMDR=01; ldMDR on mem_ready, then -> LDWB(27).
- LDWB(27): enaMDR, regWE, ldCC -> FETCH0.
- ST(3): selEAB2=10, enaMARM, ldMAR -> STMDR(23).
- STMDR(23): SR1=IR[11:9], aluControl=00, enaALU, selMDR=00, ldMDR -> STMEM(16).
- STMEM(16): memEN, memWE until mem_ready -> FETCH0.
- BR(0): taken = (IR[11]&N)|(IR[10]&Z)|(IR[9]&P).
  - Taken -> BRT(22): selEAB2=10, selPC=10, ldPC -> FETCH0.
  - Not taken -> FETCH0.
- JMP(12): SR1=IR[8:6], selEAB1=1, selEAB2=00, selPC=10, ldPC -> FETCH0.
- Other opcodes: see Optional Feature.
- Wait counter: clears on entering FETCH1, LDMEM or STMEM; increments each cycle mem_ready=0.
  - Reaching MEM_TIMEOUT without mem_ready: mem_err<=1, next state IDLE.
  - mem_ready in the same cycle the count reaches MEM_TIMEOUT: the access completes normally, no error.
- run=0: checked only in FETCH0. A 0 there sends the FSM to IDLE before any signal of FETCH0 is driven. An instruction already in progress always completes.
- mem_err clears only on reset.
- Reset mid-instruction: immediate return to IDLE. Outputs go to 0 asynchronously, and no partial writes are issued after reset asserts.

Optional Feature:
- Macro: LC3_ILLEGAL_TRAP_EN.
- Defined: unsupported opcodes (4, 8, 10, 11, 13, 15 and others) go to ILL(62). ILL drives output illegal_op=1 and stays there until reset.
  - The illegal_op port exists only when the macro is defined.
- Undefined: unsupported opcodes behave as a NOP, DECODE -> FETCH0, and there is no illegal_op port.

Test Plan:
- Reset=0, then 1 with run=1, mem_ready=1 -> states 63, 18, 33, 35, 32 on consecutive posedges. FETCH0 shows enaPC=ldMAR=ldPC=1.
- IR=0x1843 (ADD R4,R1,R3) -> in state 1: DR=4, SR1=1, SR2=3, aluControl=01, regWE=ldCC=1. Next state 18.
- IR=0x2405 (LD R2), mem_ready low 3 cycles -> LDMEM held 4 cycles, ldMDR only on the ready cycle. LDWB: DR=2, regWE=1.
- IR=0x0A03 (BRnp) with Z=1 -> BR goes to 18, never ldPC. With N=1 -> BRT, selPC=10, ldPC=1.
- mem_ready tied 0, MEM_TIMEOUT=15 -> in FETCH1 for 15 cycles, then mem_err=1 and state 63.
- IR=0xD000 -> with LC3_ILLEGAL_TRAP_EN: state 62, illegal_op=1 held. Without it: next state after 32 is 18. Also assert reset=0 during STMEM -> memWE=0 immediately.
